// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use detection, multi-cycle
// op sequencing, branch/jump redirect flushes and saturating stall/flush counters.
module ex_hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           id_rs1_add_i,
  input  logic [4:0]           id_rs2_add_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [4:0]           ex_rs1_add_i,
  input  logic [4:0]           ex_rs2_add_i,
  input  logic [4:0]           ex_rd_add_i,
  input  logic                 ex_RD_mem_i,
  input  logic                 ex_multi_i,
  input  logic [1:0]           ex_sel_alu1_i,
  input  logic [1:0]           ex_sel_alu2_i,
  input  logic [4:0]           mem_rd_add_i,
  input  logic                 mem_regwrite_i,
  input  logic [4:0]           wb_rd_add_i,
  input  logic                 wb_regwrite_i,
  input  logic                 mem_branch_i,
  input  logic                 mem_zero_i,
  input  logic                 mem_jump_i,
  output logic [1:0]           forwardA,
  output logic [1:0]           forwardB,
  output logic                 hazard,
  output logic                 redirect_o,
  output logic                 stall_pc_o,
  output logic                 stall_ifid_o,
  output logic                 stall_idex_o,
  output logic                 flush_ifid_o,
  output logic                 flush_idex_o,
  output logic                 flush,
  output logic                 mul_done_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int unsigned BUSY_W    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam int unsigned BUSY_INIT = MUL_LATENCY - 2;

  localparam logic [1:0] SEL_WB   = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;
  localparam logic [1:0] SEL_REG1 = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BUSY_W-1:0]   cnt_q, cnt_d;

  logic                take_redirect;
  logic                load_use;
  logic                fwd_a_mem, fwd_a_wb;
  logic                fwd_b_mem, fwd_b_wb;

  // Operand forwarding: only register-sourced operands are candidates, MEM beats WB.
  always_comb begin
    fwd_a_mem = 1'b0;
    fwd_a_wb  = 1'b0;
    fwd_b_mem = 1'b0;
    fwd_b_wb  = 1'b0;
    if ((ex_sel_alu1_i == SEL_REG1) && (ex_rs1_add_i != 5'd0)) begin
      fwd_a_mem = mem_regwrite_i && (mem_rd_add_i == ex_rs1_add_i);
      fwd_a_wb  = !fwd_a_mem && wb_regwrite_i && (wb_rd_add_i == ex_rs1_add_i);
    end
    if ((ex_sel_alu2_i == SEL_PC) && (ex_rs2_add_i != 5'd0)) begin
      fwd_b_mem = mem_regwrite_i && (mem_rd_add_i == ex_rs2_add_i);
      fwd_b_wb  = !fwd_b_mem && wb_regwrite_i && (wb_rd_add_i == ex_rs2_add_i);
    end
  end

  always_comb begin
    forwardA = ex_sel_alu1_i;
    forwardB = ex_sel_alu2_i;
    if (fwd_a_mem)     forwardA = SEL_MEM;
    else if (fwd_a_wb) forwardA = SEL_WB;
    if (fwd_b_mem)     forwardB = SEL_MEM;
    else if (fwd_b_wb) forwardB = SEL_WB;
    hazard = fwd_a_mem || fwd_a_wb || fwd_b_mem || fwd_b_wb;
  end

  always_comb begin
    take_redirect = mem_jump_i || (mem_branch_i && mem_zero_i);
    load_use      = ex_RD_mem_i && (ex_rd_add_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_add_i == ex_rd_add_i)) ||
                     (id_rs2_used_i && (id_rs2_add_i == ex_rd_add_i)));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a redirect aborts any multi-cycle op in flight
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (take_redirect) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_multi_i) begin
            state_d = ST_BUSY;
            cnt_d   = BUSY_W'(BUSY_INIT);
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) cnt_d   = cnt_q - BUSY_W'(1);
          else             state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: redirect > multi-cycle > load-use; all controls held low while in reset
  always_comb begin
    redirect_o   = 1'b0;
    stall_pc_o   = 1'b0;
    stall_ifid_o = 1'b0;
    stall_idex_o = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    flush        = 1'b0;
    mul_done_o   = 1'b0;
    if (rst_n) begin
      if (take_redirect) begin
        redirect_o   = 1'b1;
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
        flush        = 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (ex_multi_i) begin
              stall_pc_o   = 1'b1;
              stall_ifid_o = 1'b1;
              stall_idex_o = 1'b1;
              flush        = 1'b1;
            end else if (load_use) begin
              stall_pc_o   = 1'b1;
              stall_ifid_o = 1'b1;
              flush_idex_o = 1'b1;
            end
          end
          ST_BUSY: begin
            if (cnt_q != '0) begin
              stall_pc_o   = 1'b1;
              stall_ifid_o = 1'b1;
              stall_idex_o = 1'b1;
              flush        = 1'b1;
            end else begin
              mul_done_o   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_pc_o && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      if (redirect_o && (flush_cnt_o != {CNT_WIDTH{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: a behavioural model predicts every output
// each cycle; predictions are queued at drive time and retired when sampled.
module tb_ex_hazard_ctrl;

  localparam int unsigned ML = 4;
  localparam int unsigned CW = 16;

  logic clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_u1, id_u2, ex_ld, ex_multi, mem_we, wb_we, br, zr, jmp;
  logic [1:0] sel1, sel2;
  logic [1:0] forwardA, forwardB;
  logic hazard, redirect_o, stall_pc_o, stall_ifid_o, stall_idex_o;
  logic flush_ifid_o, flush_idex_o, flush, mul_done_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  ex_hazard_ctrl #(.MUL_LATENCY(ML), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_add_i(id_rs1), .id_rs2_add_i(id_rs2),
    .id_rs1_used_i(id_u1), .id_rs2_used_i(id_u2),
    .ex_rs1_add_i(ex_rs1), .ex_rs2_add_i(ex_rs2), .ex_rd_add_i(ex_rd),
    .ex_RD_mem_i(ex_ld), .ex_multi_i(ex_multi),
    .ex_sel_alu1_i(sel1), .ex_sel_alu2_i(sel2),
    .mem_rd_add_i(mem_rd), .mem_regwrite_i(mem_we),
    .wb_rd_add_i(wb_rd), .wb_regwrite_i(wb_we),
    .mem_branch_i(br), .mem_zero_i(zr), .mem_jump_i(jmp),
    .forwardA(forwardA), .forwardB(forwardB), .hazard(hazard),
    .redirect_o(redirect_o), .stall_pc_o(stall_pc_o),
    .stall_ifid_o(stall_ifid_o), .stall_idex_o(stall_idex_o),
    .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o), .flush(flush),
    .mul_done_o(mul_done_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct packed {
    logic [1:0] fa, fb;
    logic hz, rd, sp, si, sx, fi, fx, fl, md;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;

  // model state: m_left = cycles still owed to a multi-cycle op (0 = running)
  int unsigned m_left;
  logic [15:0] m_sc, m_fc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_left = 0;
    m_sc   = 16'h0;
    m_fc   = 16'h0;
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    logic taken, lu;
    e = '0;
    e.fa = sel1;
    e.fb = sel2;
    if (sel1 == 2'b11 && ex_rs1 != 5'd0) begin
      if (mem_we && mem_rd == ex_rs1)     e.fa = 2'b01;
      else if (wb_we && wb_rd == ex_rs1)  e.fa = 2'b00;
    end
    if (sel2 == 2'b10 && ex_rs2 != 5'd0) begin
      if (mem_we && mem_rd == ex_rs2)     e.fb = 2'b01;
      else if (wb_we && wb_rd == ex_rs2)  e.fb = 2'b00;
    end
    e.hz = (e.fa != sel1) || (e.fb != sel2);
    e.sc = m_sc;
    e.fc = m_fc;
    if (!rst_n) return e;
    taken = jmp || (br && zr);
    lu = ex_ld && ex_rd != 5'd0 && ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
    if (taken) begin
      e.rd = 1'b1; e.fi = 1'b1; e.fx = 1'b1; e.fl = 1'b1;
    end else if (m_left == 0) begin
      if (ex_multi) begin
        e.sp = 1'b1; e.si = 1'b1; e.sx = 1'b1; e.fl = 1'b1;
      end else if (lu) begin
        e.sp = 1'b1; e.si = 1'b1; e.fx = 1'b1;
      end
    end else if (m_left == 1) begin
      e.md = 1'b1;
    end else begin
      e.sp = 1'b1; e.si = 1'b1; e.sx = 1'b1; e.fl = 1'b1;
    end
    return e;
  endfunction

  task automatic model_commit(input exp_t e);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (e.sp && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (e.rd && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (e.rd)              m_left = 0;
      else if (m_left == 0)  m_left = ex_multi ? ML - 1 : 0;
      else                   m_left = m_left - 1;
    end
  endtask

  task automatic compare(input exp_t p);
    check_eq("forwardA",  32'(forwardA),     32'(p.fa));
    check_eq("forwardB",  32'(forwardB),     32'(p.fb));
    check_eq("hazard",    32'(hazard),       32'(p.hz));
    check_eq("redirect",  32'(redirect_o),   32'(p.rd));
    check_eq("stall_pc",  32'(stall_pc_o),   32'(p.sp));
    check_eq("stall_ifid",32'(stall_ifid_o), 32'(p.si));
    check_eq("stall_idex",32'(stall_idex_o), 32'(p.sx));
    check_eq("flush_ifid",32'(flush_ifid_o), 32'(p.fi));
    check_eq("flush_idex",32'(flush_idex_o), 32'(p.fx));
    check_eq("flush",     32'(flush),        32'(p.fl));
    check_eq("mul_done",  32'(mul_done_o),   32'(p.md));
    check_eq("stall_cnt", 32'(stall_cnt_o),  32'(p.sc));
    check_eq("flush_cnt", 32'(flush_cnt_o),  32'(p.fc));
  endtask

  // one checked cycle: inputs already driven, called after the falling edge
  task automatic cycle();
    exp_t e, p;
    if (!rst_n) model_clear();
    e = model_eval();
    sb_q.push_back(e);
    #1;
    p = sb_q.pop_front();
    compare(p);
    @(posedge clk);
    model_commit(e);
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = model_eval();
      @(posedge clk);
      model_commit(e);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_u1 = 1'b0; id_u2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_ld = 1'b0; ex_multi = 1'b0;
    sel1 = 2'b10; sel2 = 2'b11;
    mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd0; wb_we = 1'b0;
    br = 1'b0; zr = 1'b0; jmp = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset();
    cycle();

    // back-to-back ALU dependency
    sel1 = 2'b11; ex_rs1 = 5'd5; mem_rd = 5'd5; mem_we = 1'b1;
    sel2 = 2'b11; ex_rs2 = 5'd5;
    #1;
    check_eq("t1_fwd_a", 32'(forwardA), 32'd1);
    check_eq("t1_hazard", 32'(hazard), 32'd1);
    check_eq("t1_fwd_b_imm", 32'(forwardB), 32'd3);
    cycle();
    wb_rd = 5'd5; wb_we = 1'b1;
    #1 check_eq("t1_mem_over_wb", 32'(forwardA), 32'd1);
    cycle();
    mem_we = 1'b0; cycle();
    sel2 = 2'b10; ex_rs2 = 5'd9; wb_rd = 5'd9; cycle();
    ex_rs1 = 5'd0; mem_rd = 5'd0; mem_we = 1'b1; cycle();
    for (int i = 0; i < 40; i++) begin
      sel1 = 2'($urandom_range(3)); sel2 = 2'($urandom_range(3));
      ex_rs1 = 5'($urandom_range(3)); ex_rs2 = 5'($urandom_range(3));
      mem_rd = 5'($urandom_range(3)); wb_rd = 5'($urandom_range(3));
      mem_we = 1'($urandom_range(1)); wb_we = 1'($urandom_range(1));
      cycle();
    end

    // load-use on x7, then on x0
    do_reset();
    ex_ld = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_u1 = 1'b1;
    #1 check_eq("ld_stall", 32'({stall_pc_o, stall_ifid_o, flush_idex_o}), 32'd7);
    cycle();
    ex_ld = 1'b0; ex_rd = 5'd0; cycle();
    check_eq("ld_cnt", 32'(stall_cnt_o), 32'd1);
    ex_ld = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_u2 = 1'b1; cycle();
    check_eq("ld_x0_cnt", 32'(stall_cnt_o), 32'd1);
    ex_rd = 5'd3; id_rs2 = 5'd3; id_u1 = 1'b0; cycle();
    ex_ld = 1'b0; cycle();

    // multi-cycle op, ex_multi held while it occupies EX
    do_reset();
    ex_multi = 1'b1;
    for (int i = 0; i < ML; i++) cycle();
    ex_multi = 1'b0; cycle();
    check_eq("mul_cnt", 32'(stall_cnt_o), 32'd3);

    // taken branch while BUSY with cnt=1
    do_reset();
    ex_multi = 1'b1; cycle(); cycle();
    br = 1'b1; zr = 1'b1;
    #1 check_eq("br_stall", 32'(stall_pc_o), 32'd0);
    cycle();
    br = 1'b0; zr = 1'b0; ex_multi = 1'b0; cycle();
    check_eq("br_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // jump in the final BUSY cycle suppresses mul_done
    do_reset();
    ex_multi = 1'b1; cycle(); cycle(); cycle();
    jmp = 1'b1;
    #1 check_eq("jmp_done", 32'(mul_done_o), 32'd0);
    cycle();
    jmp = 1'b0; ex_multi = 1'b0; cycle();

    // load-use together with redirect: redirect only, no stall count
    do_reset();
    ex_ld = 1'b1; ex_rd = 5'd4; id_rs2 = 5'd4; id_u2 = 1'b1; br = 1'b1; zr = 1'b1; cycle();
    br = 1'b0; zr = 1'b0; ex_ld = 1'b0; cycle();
    check_eq("lu_redir_cnt", 32'(stall_cnt_o), 32'd0);

    // async reset in the middle of BUSY
    do_reset();
    ex_multi = 1'b1; cycle(); cycle();
    #2 rst_n = 1'b0;
    #1 check_eq("rst_stall", 32'(stall_pc_o), 32'd0);
    check_eq("rst_cnt", 32'(stall_cnt_o), 32'd0);
    cycle();
    ex_multi = 1'b0; rst_n = 1'b1; cycle();

    // stall counter saturation under a held load-use
    do_reset();
    ex_ld = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_u1 = 1'b1;
    quiet(65540);
    cycle(); cycle();
    check_eq("sat_cnt", 32'(stall_cnt_o), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
